mem_arbiter: RTL and testbench

Two-port arbiter that shares a single memory_sync instance between the instruction-fetch port and the data port of the pipelined cpu. It serialises accesses and holds the memory interface stable for a fixed multi-cycle access latency. It then returns read data to the winning requester with a one-cycle ready pulse. It replaces the separate imem/dmem pair when the design moves to a unified memory; the cpu stalls any stage whose request has not yet seen ready.

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory_sync between the fetch and data ports, holding each access for LATENCY cycles.
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating priority on simultaneous requests.
module mem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_req,
   input  logic              d_rw,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              m_enable,
   output logic              m_rw,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              owner_q;   // 1 = data port
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              i_ready_q;
   logic              d_ready_q;
   logic              win_d;     // 1 = data port wins this IDLE cycle

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q;                 // 1 = data was granted last

   always_comb begin
      win_d = d_req & (~i_req | ~last_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q <= 1'b0;
      end else if (state_q == IDLE && (i_req || d_req)) begin
         last_q <= win_d;
      end
   end
`else
   always_comb begin
      win_d = d_req;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         owner_q   <= 1'b0;
         rw_q      <= 1'b1;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
      end else begin
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_req || d_req) begin
                  owner_q <= win_d;
                  rw_q    <= win_d ? d_rw : 1'b1;
                  addr_q  <= win_d ? d_addr : i_addr;
                  wdata_q <= d_wdata;
                  cnt_q   <= CNT_INIT;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt_q == '0) begin
                  // Read data is sampled in the last cycle the memory is enabled.
                  if (rw_q) begin
                     if (owner_q) d_rdata_q <= m_rdata;
                     else         i_rdata_q <= m_rdata;
                  end
                  i_ready_q <= ~owner_q;
                  d_ready_q <= owner_q;
                  state_q   <= RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m_enable = (state_q == ACCESS);
   assign m_rw     = rw_q;
   assign m_addr   = addr_q;
   assign m_wdata  = wdata_q;
   assign i_rdata  = i_rdata_q;
   assign d_rdata  = d_rdata_q;
   assign i_ready  = i_ready_q;
   assign d_ready  = d_ready_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against an edge-timeline reference model.
// Honours ARB_ROUND_ROBIN_EN in its expected arbitration.
module tb_mem_arbiter;

   localparam int unsigned LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_rdata;
   logic        i_ready;
   logic        d_req = 1'b0;
   logic        d_rw = 1'b1;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        m_enable, m_rw, busy;
   logic [31:0] m_addr, m_wdata, m_rdata;

   logic        i1_req = 1'b0;
   logic [31:0] i1_addr = '0;
   logic [31:0] i1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;
   logic        i1_ready, d1_ready, m1_enable, m1_rw, busy1;

   logic [31:0] env_mem [0:255];
   logic [31:0] shadow  [0:255];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .m_enable(m_enable), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .busy(busy)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .i_req(i1_req), .i_addr(i1_addr), .i_rdata(i1_rdata), .i_ready(i1_ready),
      .d_req(1'b0), .d_rw(1'b1), .d_addr(32'h0), .d_wdata(32'h0),
      .d_rdata(d1_rdata), .d_ready(d1_ready),
      .m_enable(m1_enable), .m_rw(m1_rw), .m_addr(m1_addr), .m_wdata(m1_wdata),
      .m_rdata(m1_rdata), .busy(busy1)
   );

   // Environment memory: combinational read, write while enabled.
   assign m_rdata  = env_mem[m_addr[9:2]];
   assign m1_rdata = env_mem[m1_addr[9:2]];
   always @(posedge clk) if (m_enable && !m_rw) env_mem[m_addr[9:2]] <= m_wdata;

   // Reference model: grant at sampling edge g, ready visible after edge g+LAT, next grant at g+LAT+2.
   int unsigned edge_n, g_edge, next_edge;
   bit          have, own_d, mrw, lg;
   logic [31:0] maddr, mwd, exp_i, exp_d;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         edge_n = 0; g_edge = 0; next_edge = 0; have = 0; own_d = 0; mrw = 1;
         maddr = '0; mwd = '0; exp_i = '0; exp_d = '0; lg = 0;
      end else begin
         edge_n++;
         if (have && edge_n == g_edge + LAT && mrw) begin
            if (own_d) exp_d = shadow[maddr[9:2]];
            else       exp_i = shadow[maddr[9:2]];
         end
         if (edge_n >= next_edge && (i_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
            own_d = d_req && (!i_req || !lg);
`else
            own_d = d_req;
`endif
            lg        = own_d;
            have      = 1;
            g_edge    = edge_n;
            next_edge = edge_n + LAT + 2;
            mrw       = own_d ? d_rw : 1'b1;
            maddr     = own_d ? d_addr : i_addr;
            mwd       = d_wdata;
            if (!mrw) shadow[maddr[9:2]] = mwd;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      bit act, en;
      @(negedge clk);
      act = have && edge_n >= g_edge && edge_n <= g_edge + LAT;
      en  = have && edge_n >= g_edge && edge_n <  g_edge + LAT;
      chk("busy", busy, act);
      chk("m_enable", m_enable, en);
      chk("i_ready", i_ready, act && edge_n == g_edge + LAT && !own_d);
      chk("d_ready", d_ready, act && edge_n == g_edge + LAT && own_d);
      chk("i_rdata", i_rdata, exp_i);
      chk("d_rdata", d_rdata, exp_d);
      if (en) begin
         chk("m_addr", m_addr, maddr);
         chk("m_rw", m_rw, mrw);
         if (!mrw) chk("m_wdata", m_wdata, mwd);
      end
   endtask

   task automatic wait_rdy(input string tag, input bit port_d, input int maxc, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (((port_d ? d_ready : i_ready) !== 1'b1) && n < maxc);
      chk(tag, port_d ? d_ready : i_ready, 1'b1);
   endtask

   // Called at a negedge; asserts reset, checks outputs at once and through two held cycles.
   task automatic do_reset();
      reset = 1'b0; i_req = 1'b0; d_req = 1'b0; i1_req = 1'b0;
      #1;
      chk("rst_i_rdata", i_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_i_ready", i_ready, 1'b0);
      chk("rst_d_ready", d_ready, 1'b0);
      chk("rst_m_enable", m_enable, 1'b0);
      chk("rst_m_rw", m_rw, 1'b1);
      chk("rst_m_addr", m_addr, 32'h0);
      chk("rst_m_wdata", m_wdata, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_busy1", busy1, 1'b0);
      repeat (2) begin
         @(negedge clk);
         chk("rst_hold_ready", {d_ready, i_ready}, 32'h0);
         chk("rst_hold_busy", busy, 1'b0);
      end
      reset = 1'b1;
   endtask

   function automatic logic [31:0] rnd_addr();
      return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
   endfunction

   initial begin
      int n;
      for (int i = 0; i < 256; i++) begin
         env_mem[i] = $urandom;
         shadow[i]  = env_mem[i];
      end
      env_mem[16] = 32'h2402000A;
      shadow[16]  = 32'h2402000A;

      @(negedge clk);
      do_reset();

      // Single fetch of 0x40
      i_req = 1'b1; i_addr = 32'h40;
      cyc(); chk("t1_en_c1", m_enable, 1'b1);
      cyc(); chk("t1_en_c2", m_enable, 1'b1); chk("t1_rdy_c2", i_ready, 1'b0);
      cyc(); chk("t1_rdy_c3", i_ready, 1'b1); chk("t1_rdata", i_rdata, 32'h2402000A);
      i_req = 1'b0;
      cyc(); chk("t1_rdy_c4", i_ready, 1'b0);

      // Write then read of 0x100
      d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
      wait_rdy("t2_wr_ready", 1'b1, 10, n);
      chk("t2_wr_lat", n, 32'd3);
      chk("t2_wr_rdata_held", d_rdata, 32'h0);
      d_rw = 1'b1;
      wait_rdy("t2_rd_ready", 1'b1, 10, n);
      chk("t2_rd_lat", n, 32'd4);
      chk("t2_rd_rdata", d_rdata, 32'hDEADBEEF);
      d_req = 1'b0;
      cyc();

      // Data request one cycle after a fetch grant
      i_req = 1'b1; i_addr = 32'h80;
      cyc();
      d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h100;
      wait_rdy("t5_i_ready", 1'b0, 10, n);
      chk("t5_i_lat", n, 32'd2);
      i_req = 1'b0;
      wait_rdy("t5_d_ready", 1'b1, 10, n);
      chk("t5_d_gap", n, LAT + 2);
      d_req = 1'b0;
      cyc();

      // Reset in the second ACCESS cycle
      i_req = 1'b1; i_addr = 32'h44;
      cyc(); cyc();
      chk("t6_in_access", m_enable, 1'b1);
      do_reset();
      cyc();

      // Collision (last grant = fetch after reset)
      i_req = 1'b1; i_addr = 32'hC0;
      d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h100;
      wait_rdy("t4_d_first", 1'b1, 10, n);
      chk("t4_d_lat", n, 32'd3);
      chk("t4_i_not_yet", i_ready, 1'b0);
`ifndef ARB_ROUND_ROBIN_EN
      d_req = 1'b0;
`endif
      wait_rdy("t4_i_second", 1'b0, 10, n);
      chk("t4_i_gap", n, 32'd4);
      chk("t4_i_rdata", i_rdata, shadow[48]);
      i_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      wait_rdy("t4_d_third", 1'b1, 10, n);
      chk("t4_d_gap", n, 32'd4);
      d_req = 1'b0;
`endif
      cyc();

      // LATENCY = 1 instance, fetch held continuously
      i1_req = 1'b1; i1_addr = 32'h40;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (i1_ready !== 1'b1 && n < 8);
         chk("l1_ready", i1_ready, 1'b1);
         chk("l1_period", n, (k == 0) ? 32'd2 : 32'd3);
         chk("l1_rdata", i1_rdata, shadow[i1_addr[9:2]]);
         i1_addr = i1_addr + 32'd4;
      end
      i1_req = 1'b0;
      cyc();

      // Randomized traffic on both ports
      for (int c = 0; c < 600; c++) begin
         if (i_req && i_ready) begin
            i_req = 1'($urandom_range(0, 1)); i_addr = rnd_addr();
         end else if (!i_req && $urandom_range(0, 2) == 0) begin
            i_req = 1'b1; i_addr = rnd_addr();
         end
         if (d_req && d_ready) begin
            d_req = 1'($urandom_range(0, 1)); d_addr = rnd_addr();
            d_rw = 1'($urandom_range(0, 1)); d_wdata = $urandom;
         end else if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1; d_addr = rnd_addr();
            d_rw = 1'($urandom_range(0, 1)); d_wdata = $urandom;
         end
         cyc();
      end
      i_req = 1'b0; d_req = 1'b0;
      repeat (6) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
